// File: rtl/datapath_ctrl.sv
// Sequencing controller for an external double/subtract datapath: loads operands,
// steers the datapath mux/op selects, and captures the datapath result.
module datapath_ctrl #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [3:0]   len,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic [W-1:0] dp_in,
    output logic         sel_1_2,
    output logic         sel_3,
    input  logic [W-1:0] dp_out,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [W-1:0] result
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_DOUBLE = 2'b00,
        OP_POW    = 2'b01,
        OP_CLEAR  = 2'b10,
        OP_RSVD   = 2'b11
    } op_t;

    state_t       state_q, state_d;
    op_t          op_q, op_d;
    logic [3:0]   len_q, len_d;
    logic [3:0]   beat_q, beat_d;
    logic [5:0]   run_q, run_d;
    logic         err_q, err_d;
    logic [W-1:0] dp_in_q, dp_in_d;
    logic [W-1:0] result_q, result_d;
    logic         run_last;

    assign dp_in  = dp_in_q;
    assign result = result_q;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        len_d    = len_q;
        beat_d   = beat_q;
        run_d    = run_q;
        err_d    = err_q;
        dp_in_d  = dp_in_q;
        result_d = result_q;
        run_last = 1'b0;
        in_ready = 1'b0;
        sel_1_2  = 1'b0;
        sel_3    = 1'b0;
        busy     = (state_q != IDLE);
        done     = 1'b0;
        err      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d   = op_t'(op);
                    len_d  = len;
                    beat_d = '0;
                    run_d  = '0;
                    err_d  = 1'b0;
                    if ((op_t'(op) == OP_DOUBLE || op_t'(op) == OP_POW) && len != 4'd0) begin
                        state_d = LOAD;
                    end else if (op_t'(op) == OP_CLEAR) begin
                        state_d = RUN;
                    end else begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end
                end
            end

            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    dp_in_d = in_data;
                    beat_d  = beat_q + 4'd1;
                    if (op_q == OP_POW || beat_q == len_q - 4'd1) begin
                        state_d = RUN;
                        run_d   = '0;
                    end
                end
            end

            RUN: begin
                run_d = run_q + 6'd1;
                // The datapath's feedback loop is two registers deep, so each
                // POW doubling costs two RUN cycles after a two-cycle fill.
                case (op_q)
                    OP_DOUBLE: run_last = (run_q == 6'd2);
                    OP_POW: begin
                        sel_1_2  = (run_q >= 6'd2);
                        run_last = (run_q == {1'b0, len_q, 1'b0});
                    end
                    OP_CLEAR: begin
                        sel_1_2  = (run_q < 6'd2);
                        sel_3    = (run_q < 6'd2);
                        run_last = (run_q == 6'd2);
                    end
                    default: run_last = 1'b1;
                endcase
                if (run_last) begin
                    result_d = dp_out;
                    state_d  = DONE;
                end
            end

            DONE: begin
                done    = 1'b1;
                err     = err_q;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= OP_DOUBLE;
            len_q    <= '0;
            beat_q   <= '0;
            run_q    <= '0;
            err_q    <= 1'b0;
            dp_in_q  <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            len_q    <= len_d;
            beat_q   <= beat_d;
            run_q    <= run_d;
            err_q    <= err_d;
            dp_in_q  <= dp_in_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_datapath_ctrl.sv
// Bench for datapath_ctrl paired with a two-register double/subtract datapath;
// outputs are checked every cycle against command-level timing windows.
module tb_datapath_ctrl;

    localparam int W   = 16;
    localparam int BIG = 32'h4000_0000;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [3:0]   len = 4'd0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_ready;
    logic [W-1:0] dp_in;
    logic         sel_1_2;
    logic         sel_3;
    logic [W-1:0] dp_out;
    logic         busy;
    logic         done;
    logic         err;
    logic [W-1:0] result;

    always #5 clk = ~clk;

    datapath_ctrl #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .len(len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .dp_in(dp_in), .sel_1_2(sel_1_2), .sel_3(sel_3), .dp_out(dp_out),
        .busy(busy), .done(done), .err(err), .result(result)
    );

    // Paired datapath: mux register then double/subtract result register.
    logic [W-1:0] dp_a;
    always @(posedge clk) begin
        if (!rst_n) begin
            dp_a   <= '0;
            dp_out <= '0;
        end else begin
            dp_a   <= sel_1_2 ? dp_out : dp_in;
            dp_out <= sel_3 ? W'(dp_a - dp_a) : W'(dp_a + dp_a);
        end
    end

    // cyc = number of rising edges so far; edge n is the one that sets cyc to n.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int           busy_lo, busy_hi, load_lo, load_hi;
    int           s12_lo, s12_hi, s3_lo, s3_hi, done_at;
    logic         m_err;
    logic [W-1:0] res_old, res_new, m_dp_in;
    int           checks = 0;
    int           errors = 0;
    bit           chk_en = 1'b0;
    int           last_done = -1;
    int           last_rise = -1;
    logic         prev_s12 = 1'b0;

    function automatic logic inwin(input int lo, input int hi);
        return (cyc >= lo) && (cyc <= hi);
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 60)
                $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_clear();
        busy_lo = BIG; busy_hi = BIG;
        load_lo = BIG; load_hi = BIG;
        s12_lo  = BIG; s12_hi  = BIG;
        s3_lo   = BIG; s3_hi   = BIG;
        done_at = BIG;
        m_err   = 1'b0;
        res_old = '0;
        res_new = '0;
        m_dp_in = '0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy",     W'(busy),     W'(inwin(busy_lo, busy_hi)));
            chk("done",     W'(done),     W'(cyc == done_at));
            chk("err",      W'(err),      W'((cyc == done_at) && m_err));
            chk("in_ready", W'(in_ready), W'(inwin(load_lo, load_hi)));
            chk("sel_1_2",  W'(sel_1_2),  W'(inwin(s12_lo, s12_hi)));
            chk("sel_3",    W'(sel_3),    W'(inwin(s3_lo, s3_hi)));
            chk("dp_in",    dp_in,        m_dp_in);
            chk("result",   result,       (cyc >= done_at) ? res_new : res_old);
            if (done === 1'b1) last_done = cyc;
            if (sel_1_2 === 1'b1 && prev_s12 !== 1'b1) last_rise = cyc;
            prev_s12 = sel_1_2;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Issues one command; s_edge = start edge, e_edge = last accept edge.
    // abort_after >= 0 resets the DUT that many edges after the last accept.
    task automatic run_cmd(input logic [1:0] c_op, input logic [3:0] c_len,
                           input logic [W-1:0] beats[16], input int stalls[16],
                           input bit start_in_load, input int abort_after,
                           output int s_edge, output int e_edge);
        int nb;
        logic [W-1:0] cur;
        @(negedge clk);
        start = 1'b1; op = c_op; len = c_len;
        @(posedge clk); #1;
        s_edge  = cyc;
        e_edge  = cyc;
        cur     = (cyc >= done_at) ? res_new : res_old;
        res_old = cur; res_new = cur;
        done_at = BIG; m_err = 1'b0;
        busy_lo = s_edge; busy_hi = BIG;
        load_lo = BIG; load_hi = BIG;
        s12_lo = BIG; s12_hi = BIG; s3_lo = BIG; s3_hi = BIG;
        if (c_op == 2'b11 || (c_op != 2'b10 && c_len == 4'd0)) begin
            m_err = 1'b1; done_at = s_edge; busy_hi = s_edge;
        end else if (c_op == 2'b10) begin
            done_at = s_edge + 3; busy_hi = done_at;
            s12_lo = s_edge; s12_hi = s_edge + 1;
            s3_lo  = s_edge; s3_hi  = s_edge + 1;
            res_new = '0;
        end else begin
            load_lo = s_edge;
            nb = (c_op == 2'b00) ? int'(c_len) : 1;
        end
        @(negedge clk);
        start = 1'b0;
        if (load_lo != BIG) begin
            for (int i = 0; i < nb; i++) begin
                for (int k = 0; k < stalls[i]; k++) begin
                    in_valid = 1'b0;
                    if (start_in_load && k == 0) begin
                        start = 1'b1; op = 2'b10; len = 4'd5;
                    end
                    @(negedge clk);
                    start = 1'b0;
                end
                in_valid = 1'b1; in_data = beats[i];
                @(posedge clk); #1;
                m_dp_in = beats[i];
                if (i == nb - 1) begin
                    e_edge  = cyc;
                    load_hi = e_edge - 1;
                    done_at = (c_op == 2'b00) ? e_edge + 3 : e_edge + 2 * int'(c_len) + 1;
                    busy_hi = done_at;
                    if (c_op == 2'b01) begin
                        s12_lo  = e_edge + 2; s12_hi = done_at - 1;
                        res_new = W'(beats[0] << c_len);
                    end else begin
                        res_new = W'(beats[nb-1] * 2);
                    end
                end
                @(negedge clk);
                in_valid = 1'b0;
            end
        end
        if (abort_after >= 0) begin
            repeat (abort_after) @(posedge clk);
            do_reset();
        end else begin
            for (int n = 0; n < 200 && cyc <= done_at; n++) @(posedge clk);
            #1;
            chk("cmd_complete", W'(cyc > done_at), W'(1));
        end
    endtask

    logic [W-1:0] bt[16];
    int           st[16];
    int           s, e, done_before;

    task automatic clear_vec();
        for (int i = 0; i < 16; i++) begin
            bt[i] = '0;
            st[i] = 0;
        end
    endtask

    initial begin
        model_clear();
        clear_vec();
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_result", result, 16'h0000);
        chk("rst_busy", W'(busy), W'(0));

        // DOUBLE len=3, beats 2,3,1
        clear_vec(); bt[0] = 16'd2; bt[1] = 16'd3; bt[2] = 16'd1;
        run_cmd(2'b00, 4'd3, bt, st, 1'b0, -1, s, e);
        chk("dbl3_result", result, 16'd2);
        chk("dbl3_done_lat", W'(last_done - e), W'(3));

        // POW len=4, beat 5; sel_1_2 is 1 from the cycle after edge E+2
        clear_vec(); bt[0] = 16'd5;
        run_cmd(2'b01, 4'd4, bt, st, 1'b0, -1, s, e);
        chk("pow4_result", result, 16'd80);
        chk("pow4_done_lat", W'(last_done - e), W'(9));
        chk("pow4_sel_rise", W'(last_rise - e), W'(2));

        // DOUBLE leaving 10, then CLEAR
        clear_vec(); bt[0] = 16'd5;
        run_cmd(2'b00, 4'd1, bt, st, 1'b0, -1, s, e);
        chk("dbl1_result", result, 16'd10);
        run_cmd(2'b10, 4'd0, bt, st, 1'b0, -1, s, e);
        chk("clear_result", result, 16'd0);
        chk("clear_done_lat", W'(last_done - s), W'(3));

        // Rejected commands: done/err in the cycle right after the start edge
        clear_vec(); bt[0] = 16'd7;
        run_cmd(2'b00, 4'd1, bt, st, 1'b0, -1, s, e);
        run_cmd(2'b11, 4'd3, bt, st, 1'b0, -1, s, e);
        chk("rsvd_done_lat", W'(last_done - s), W'(0));
        run_cmd(2'b00, 4'd0, bt, st, 1'b0, -1, s, e);
        chk("dbl0_done_lat", W'(last_done - s), W'(0));
        run_cmd(2'b01, 4'd0, bt, st, 1'b0, -1, s, e);
        chk("rej_result_kept", result, 16'd14);

        // DOUBLE len=2 with a 4-cycle stall and a start pulse during LOAD
        clear_vec(); bt[0] = 16'h0011; bt[1] = 16'h0123; st[1] = 4;
        run_cmd(2'b00, 4'd2, bt, st, 1'b1, -1, s, e);
        chk("stall_result", result, 16'h0246);

        // in_valid while idle must not touch dp_in
        @(negedge clk);
        in_valid = 1'b1; in_data = 16'hBEEF;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        chk("idle_dp_in", dp_in, 16'h0123);

        // Reset mid-RUN of POW len=8, then a normal DOUBLE
        done_before = last_done;
        clear_vec(); bt[0] = 16'd3;
        run_cmd(2'b01, 4'd8, bt, st, 1'b0, 6, s, e);
        chk("abort_result", result, 16'd0);
        chk("abort_dp_in", dp_in, 16'd0);
        chk("abort_no_done", W'(last_done), W'(done_before));
        clear_vec(); bt[0] = 16'h9000; bt[1] = 16'h8001;
        run_cmd(2'b00, 4'd2, bt, st, 1'b0, -1, s, e);
        chk("post_abort_dbl_wrap", result, 16'h0002);

        // Longest POW: counter must reach 30 without wrapping
        clear_vec(); bt[0] = 16'd3;
        run_cmd(2'b01, 4'd15, bt, st, 1'b0, -1, s, e);
        chk("pow15_result", result, 16'h8000);
        chk("pow15_done_lat", W'(last_done - e), W'(31));

        clear_vec(); bt[0] = 16'h1234;
        run_cmd(2'b01, 4'd1, bt, st, 1'b0, -1, s, e);
        chk("pow1_result", result, 16'h2468);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/datapath_ctrl.md
DATAPATH_CTRL -- requirements
Module: datapath_ctrl

Interface
REQ-001 Parameter W, default 16: data width of in_data, dp_in, dp_out and result.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  command strobe; sampled only in IDLE.
REQ-005 op  input  2  command: 00 DOUBLE, 01 POW, 10 CLEAR, 11 reserved.
REQ-006 len  input  4  DOUBLE: operand count; POW: doubling count.
REQ-007 in_valid  input  1  operand valid.
REQ-008 in_data  input  W  operand.
REQ-009 in_ready  output  1  controller accepts an operand this cycle.
REQ-010 dp_in  output  W  registered operand to the double/subtract datapath.
REQ-011 sel_1_2  output  1  datapath mux select: 0 = input register, 1 = feedback register.
REQ-012 sel_3  output  1  datapath op select: 0 = add, 1 = subtract.
REQ-013 dp_out  input  W  datapath result register.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle completion pulse.
REQ-016 err  output  1  high together with done when the command was rejected.
REQ-017 result  output  W  captured datapath result; held until the next capture.

Function
REQ-018 States SHALL be IDLE, LOAD, RUN and DONE only.
REQ-019 In IDLE, start=1 SHALL latch op and len and transition to LOAD for DOUBLE or POW with len!=0, to RUN for CLEAR, and to DONE for any other case.
REQ-020 A rejected command (op=11, or DOUBLE/POW with len=0) SHALL set err=1 in DONE and leave result unchanged.
REQ-021 in_ready SHALL be 1 only in LOAD; a beat is accepted on an edge where in_valid and in_ready are both 1.
REQ-022 Each accepted beat SHALL register dp_in <= in_data; at all other times dp_in holds its value.
REQ-023 LOAD SHALL accept len beats for DOUBLE and exactly 1 beat for POW, then transition to RUN.
REQ-024 Let E be the edge that accepts the last LOAD beat. DOUBLE SHALL hold sel_1_2=0 and sel_3=0, and SHALL capture result <= dp_out at edge E+3.
REQ-025 POW SHALL hold sel_1_2=0 through edge E+2 and sel_1_2=1 from edge E+3 onward, with sel_3=0 throughout. It SHALL capture result <= dp_out at edge E+2*len+1, giving result = operand * 2^len mod 2^W.
REQ-026 CLEAR SHALL assert sel_3=1 and sel_1_2=1 for 2 cycles after leaving IDLE, then capture result <= dp_out (= 0).
REQ-027 The capture edge SHALL also transition to DONE. DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-028 Outside RUN, sel_1_2 and sel_3 SHALL be 0.
REQ-029 All arithmetic is modulo 2^W; an internal RUN cycle counter SHALL be at least 6 bits wide so that len=15 (31 cycles) does not wrap.
REQ-030 start while busy=1 SHALL be ignored with no queuing; in_valid outside LOAD SHALL be ignored.
REQ-031 Stalls (in_valid=0 in LOAD) SHALL hold state and count indefinitely.

Reset
REQ-032 rst_n=0 at a clock edge SHALL force IDLE, clear the counters, and drive in_ready=0, dp_in=0, sel_1_2=0, sel_3=0, busy=0, done=0, err=0 and result=0.
REQ-033 Reset in any state, including mid-LOAD or mid-RUN, SHALL abort the command without producing a done pulse.

Verification (controller paired with the datapath)
REQ-034 DOUBLE, len=3, beats 2, 3, 1 with no stalls -> done 3 edges after the third beat, result=2, err=0.
REQ-035 POW, len=4, beat 5 -> done at accept edge + 9, result=80; sel_1_2 rises at accept edge + 3.
REQ-036 CLEAR after a DOUBLE that left result=10 -> result=0 and done 3 cycles after start.
REQ-037 op=11, then DOUBLE with len=0 -> each produces done=1 and err=1 on the cycle after start, result unchanged, in_ready never asserted.
REQ-038 DOUBLE, len=2, in_valid stalled for 4 cycles between beats, start pulsed during LOAD -> stall absorbed, start ignored, result = 2 * second beat.
REQ-039 rst_n=0 mid-RUN of POW len=8 -> all outputs 0 on the next edge, no done pulse, and a following DOUBLE completes normally.
